cache_request_queue: RTL and testbench



---
 rtl/cache_types_pkg.sv | 21 ++
 rtl/cache_request_queue_uuid_allocator.sv | 49 ++++
 rtl/cache_request_queue.sv | 94 +++++++++
 tb/tb_cache_request_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Types shared by the cache request queue and lockup_free_cache.
package cache_types_pkg;

   localparam int UUID_W = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   // Request fields that travel with a tag through the queue.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rw_mode;
      logic [DATA_W-1:0] store_value;
   } req_payload_t;

   // Complete queue entry as seen by the cache.
   typedef struct packed {
      logic [UUID_W-1:0] uuid;
      req_payload_t      payload;
   } req_entry_t;

endpackage

// File: rtl/cache_request_queue_uuid_allocator.sv
// Tag pool: busy vector, lowest-free-tag encoder and release handling.
module uuid_allocator #(
   parameter int UUID_W = cache_types_pkg::UUID_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              alloc_en,
   output logic              any_free,
   output logic [UUID_W-1:0] free_uuid,
   input  logic              hit_rel_en,
   input  logic [UUID_W-1:0] hit_rel_uuid,
   input  logic              resp_rel_en,
   input  logic [UUID_W-1:0] resp_rel_uuid
);

   localparam int NT = 1 << UUID_W;

   logic [NT-1:0] busy;
   logic [NT-1:0] set_mask;
   logic [NT-1:0] clr_mask;

   // Lowest-index free tag; scanning downward lets the lowest index win.
   always_comb begin
      free_uuid = '0;
      any_free  = 1'b0;
      for (int i = NT - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_uuid = UUID_W'(i);
            any_free  = 1'b1;
         end
      end
   end

   // Set/clear masks; two releases of one tag simply OR together.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (alloc_en)    set_mask[free_uuid]     = 1'b1;
      if (hit_rel_en)  clr_mask[hit_rel_uuid]  = 1'b1;
      if (resp_rel_en) clr_mask[resp_rel_uuid] = 1'b1;
   end

   // Clear before set, so a stray release of the tag being allocated is a no-op.
   always_ff @(posedge CLK) begin
      if (nRST) busy <= '0;
      else      busy <= (busy & ~clr_mask) | set_mask;
   end

endmodule

// File: rtl/cache_request_queue.sv
// Circular request FIFO between the core and the cache, with tag allocation.
module cache_request_queue
   import cache_types_pkg::req_payload_t;
#(
   parameter int DEPTH  = 8,
   parameter int UUID_W = cache_types_pkg::UUID_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              req_valid,
   input  logic [31:0]       req_addr,
   input  logic              req_rw_mode,
   input  logic [31:0]       req_store_value,
   output logic              req_ready,
   output logic [UUID_W-1:0] req_uuid,
   output logic              mem_in,
   output logic [UUID_W-1:0] mem_in_uuid,
   output logic [31:0]       mem_in_addr,
   output logic              mem_in_rw_mode,
   output logic [31:0]       mem_in_store_value,
   input  logic              stall,
   input  logic              hit,
   input  logic              resp_valid,
   input  logic [UUID_W-1:0] resp_uuid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [UUID_W-1:0] uuid_mem [DEPTH];
   req_payload_t      pay_mem  [DEPTH];
   logic [PW-1:0]     head, tail;
   logic [CW-1:0]     count;
   logic              any_free, push, pop;

   // Readiness comes from registered state only, never from this cycle's pop.
   assign req_ready = (count != CW'(DEPTH)) && any_free;
   assign push      = req_valid && req_ready;
   assign mem_in    = (count != '0);
   assign pop       = mem_in && !stall;

   uuid_allocator #(.UUID_W(UUID_W)) u_alloc (
      .CLK          (CLK),
      .nRST         (nRST),
      .alloc_en     (push),
      .any_free     (any_free),
      .free_uuid    (req_uuid),
      .hit_rel_en   (pop && hit),
      .hit_rel_uuid (uuid_mem[head]),
      .resp_rel_en  (resp_valid),
      .resp_rel_uuid(resp_uuid)
   );

   // Head entry fields, forced to zero while the queue is empty.
   always_comb begin
      mem_in_uuid        = '0;
      mem_in_addr        = '0;
      mem_in_rw_mode     = 1'b0;
      mem_in_store_value = '0;
      if (mem_in) begin
         mem_in_uuid        = uuid_mem[head];
         mem_in_addr        = pay_mem[head].addr;
         mem_in_rw_mode     = pay_mem[head].rw_mode;
         mem_in_store_value = pay_mem[head].store_value;
      end
   end

   // Entry storage; contents are only meaningful between tail and head, so no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         uuid_mem[tail] <= req_uuid;
         pay_mem[tail]  <= '{addr: req_addr, rw_mode: req_rw_mode,
                            store_value: req_store_value};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_request_queue.sv
// Directed bench for cache_request_queue with hand-computed expectations.
module tb_cache_request_queue;

   logic        CLK = 1'b0;
   logic        nRST = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_rw_mode = 1'b0;
   logic [31:0] req_store_value = '0;
   logic        req_ready;
   logic [3:0]  req_uuid;
   logic        mem_in;
   logic [3:0]  mem_in_uuid;
   logic [31:0] mem_in_addr;
   logic        mem_in_rw_mode;
   logic [31:0] mem_in_store_value;
   logic        stall = 1'b0;
   logic        hit = 1'b0;
   logic        resp_valid = 1'b0;
   logic [3:0]  resp_uuid = '0;

   int errors = 0;
   int checks = 0;

   cache_request_queue #(.DEPTH(8), .UUID_W(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .req_valid(req_valid), .req_addr(req_addr), .req_rw_mode(req_rw_mode),
      .req_store_value(req_store_value), .req_ready(req_ready), .req_uuid(req_uuid),
      .mem_in(mem_in), .mem_in_uuid(mem_in_uuid), .mem_in_addr(mem_in_addr),
      .mem_in_rw_mode(mem_in_rw_mode), .mem_in_store_value(mem_in_store_value),
      .stall(stall), .hit(hit), .resp_valid(resp_valid), .resp_uuid(resp_uuid)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end, got running want finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      req_valid = 0; stall = 0; hit = 0; resp_valid = 0;
      nRST = 1; tick(); nRST = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (req_ready !== 1'b1 || req_uuid !== 4'd0 || mem_in !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b uuid=%0d mem_in=%b want 1 0 0", req_ready, req_uuid, mem_in);
      end
      checks++;
      if (mem_in_uuid !== 4'd0 || mem_in_addr !== 32'd0 || mem_in_rw_mode !== 1'b0 || mem_in_store_value !== 32'd0) begin
         errors++;
         $display("FAIL reset_fields: uuid=%0d addr=%h rw=%b data=%h want all 0",
                  mem_in_uuid, mem_in_addr, mem_in_rw_mode, mem_in_store_value);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      stall = 0; hit = 1;
      req_valid = 1; req_addr = 32'h100; req_rw_mode = 0; req_store_value = 32'hdead;
      checks++;
      if (req_ready !== 1'b1 || req_uuid !== 4'd0) begin
         errors++;
         $display("FAIL single_accept: ready=%b uuid=%0d want 1 0", req_ready, req_uuid);
      end
      tick(); req_valid = 0;
      checks++;
      if (mem_in !== 1'b1 || mem_in_uuid !== 4'd0 || mem_in_addr !== 32'h100 || mem_in_rw_mode !== 1'b0) begin
         errors++;
         $display("FAIL single_present: mem_in=%b uuid=%0d addr=%h rw=%b want 1 0 100 0",
                  mem_in, mem_in_uuid, mem_in_addr, mem_in_rw_mode);
      end
      checks++;
      if (req_uuid !== 4'd1) begin
         errors++;
         $display("FAIL single_tag_busy: uuid=%0d want 1", req_uuid);
      end
      tick();
      checks++;
      if (mem_in !== 1'b0 || req_uuid !== 4'd0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_tag_freed: mem_in=%b uuid=%0d ready=%b want 0 0 1", mem_in, req_uuid, req_ready);
      end
   endtask

   task automatic test_fill_stall();
      do_reset();
      stall = 1; hit = 1; req_rw_mode = 1;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1; req_addr = 32'h200 + 32'(i * 4); req_store_value = 32'(i + 100);
         checks++;
         if (req_ready !== 1'b1 || req_uuid !== 4'(i)) begin
            errors++;
            $display("FAIL fill_push%0d: ready=%b uuid=%0d want 1 %0d", i, req_ready, req_uuid, i);
         end
         tick();
      end
      req_valid = 1; req_addr = 32'h999;
      checks++;
      if (req_ready !== 1'b0 || mem_in_addr !== 32'h200 || mem_in_uuid !== 4'd0 || mem_in_store_value !== 32'd100) begin
         errors++;
         $display("FAIL fill_full: ready=%b addr=%h uuid=%0d data=%0d want 0 200 0 100",
                  req_ready, mem_in_addr, mem_in_uuid, mem_in_store_value);
      end
      tick(); req_valid = 0; stall = 0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (mem_in !== 1'b1 || mem_in_addr !== 32'h200 + 32'(i * 4) || mem_in_uuid !== 4'(i) || mem_in_rw_mode !== 1'b1) begin
            errors++;
            $display("FAIL drain_pop%0d: mem_in=%b addr=%h uuid=%0d rw=%b want 1 %h %0d 1",
                     i, mem_in, mem_in_addr, mem_in_uuid, mem_in_rw_mode, 32'h200 + 32'(i * 4), i);
         end
         tick();
      end
      checks++;
      if (mem_in !== 1'b0 || req_uuid !== 4'd0) begin
         errors++;
         $display("FAIL drain_empty: mem_in=%b uuid=%0d want 0 0", mem_in, req_uuid);
      end
   endtask

   task automatic test_tag_exhaust();
      do_reset();
      stall = 0; hit = 0; req_rw_mode = 0;
      for (int i = 0; i < 16; i++) begin
         req_valid = 1; req_addr = 32'h1000 + 32'(i);
         checks++;
         if (req_ready !== 1'b1 || req_uuid !== 4'(i)) begin
            errors++;
            $display("FAIL exhaust_push%0d: ready=%b uuid=%0d want 1 %0d", i, req_ready, req_uuid, i);
         end
         tick();
      end
      checks++;
      if (req_ready !== 1'b0 || req_uuid !== 4'd0 || mem_in !== 1'b1) begin
         errors++;
         $display("FAIL exhaust_no_tag: ready=%b uuid=%0d mem_in=%b want 0 0 1", req_ready, req_uuid, mem_in);
      end
      req_valid = 0; resp_valid = 1; resp_uuid = 4'd5;
      tick(); resp_valid = 0;
      checks++;
      if (req_ready !== 1'b1 || req_uuid !== 4'd5) begin
         errors++;
         $display("FAIL exhaust_retire5: ready=%b uuid=%0d want 1 5", req_ready, req_uuid);
      end
      req_valid = 1; tick(); req_valid = 0;
      checks++;
      if (req_ready !== 1'b0 || mem_in_uuid !== 4'd5) begin
         errors++;
         $display("FAIL exhaust_reuse: ready=%b head_uuid=%0d want 0 5", req_ready, mem_in_uuid);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      stall = 1; hit = 1;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1; req_addr = 32'(i); tick();
      end
      stall = 0; req_valid = 1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_push: ready=%b want 0", req_ready);
      end
      tick(); req_valid = 0; stall = 1;
      checks++;
      if (req_ready !== 1'b1 || mem_in_uuid !== 4'd1 || req_uuid !== 4'd0) begin
         errors++;
         $display("FAIL full_after_pop: ready=%b head=%0d uuid=%0d want 1 1 0", req_ready, mem_in_uuid, req_uuid);
      end
      req_valid = 1; tick(); req_valid = 0;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_count7: ready=%b want 0 after one refill", req_ready);
      end
      do_reset();
      stall = 1; hit = 0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1; tick();
      end
      stall = 0; req_valid = 1;
      tick();
      stall = 1;
      n = 0;
      while (req_ready === 1'b1 && n < 10) begin
         n++; tick();
      end
      req_valid = 0;
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL count3_hold: extra pushes=%0d want 5", n);
      end
   endtask

   task automatic test_release_corner();
      do_reset();
      stall = 0; hit = 0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1; tick();
      end
      req_valid = 0; resp_valid = 1; resp_uuid = 4'd9;
      tick(); resp_valid = 0;
      checks++;
      if (req_uuid !== 4'd3 || mem_in !== 1'b0) begin
         errors++;
         $display("FAIL free_release: uuid=%0d mem_in=%b want 3 0", req_uuid, mem_in);
      end
      stall = 1; req_valid = 1; tick(); req_valid = 0;
      stall = 0; hit = 1; resp_valid = 1; resp_uuid = 4'd3;
      checks++;
      if (mem_in_uuid !== 4'd3 || req_uuid !== 4'd4) begin
         errors++;
         $display("FAIL dual_before: head=%0d uuid=%0d want 3 4", mem_in_uuid, req_uuid);
      end
      tick(); resp_valid = 0; hit = 0;
      checks++;
      if (req_uuid !== 4'd3 || mem_in !== 1'b0) begin
         errors++;
         $display("FAIL dual_release: uuid=%0d mem_in=%b want 3 0", req_uuid, mem_in);
      end
      resp_valid = 1; resp_uuid = 4'd1; tick(); resp_valid = 0;
      checks++;
      if (req_uuid !== 4'd1) begin
         errors++;
         $display("FAIL release1: uuid=%0d want 1", req_uuid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      stall = 0; hit = 0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1; tick();
      end
      req_valid = 0; tick();
      stall = 1;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1; req_addr = 32'h3000 + 32'(i); tick();
      end
      req_valid = 0;
      checks++;
      if (req_uuid !== 4'd9 || mem_in_uuid !== 4'd4) begin
         errors++;
         $display("FAIL mid_setup: uuid=%0d head=%0d want 9 4", req_uuid, mem_in_uuid);
      end
      nRST = 1; tick(); nRST = 0;
      checks++;
      if (mem_in !== 1'b0 || req_uuid !== 4'd0 || req_ready !== 1'b1 || mem_in_addr !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset: mem_in=%b uuid=%0d ready=%b addr=%h want 0 0 1 0",
                  mem_in, req_uuid, req_ready, mem_in_addr);
      end
      stall = 0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_fill_stall();
      test_tag_exhaust();
      test_back_to_back();
      test_release_corner();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
